// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the push-button / slide-switch debouncer.
package input_debouncer_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } deb_state_e;

   localparam int CLK_FREQ_HZ             = 100_000_000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;  // 20 ms at CLK_FREQ_HZ

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/input_debouncer_core.sv
// One debounce engine: two-flop synchronizer, then a STABLE/SETTLING FSM that
// accepts a new vector after DEBOUNCE_CYCLES consecutive identical samples.
module debounce_core
   import input_debouncer_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable,
   output logic             changed
);

   localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1, sync2;
   logic [WIDTH-1:0] cand;
   logic [CW-1:0]    cnt;
   deb_state_e       state;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         cand    <= '0;
         cnt     <= '0;
         stable  <= '0;
         changed <= 1'b0;
         state   <= STABLE;
      end else begin
         sync1   <= din;
         sync2   <= sync1;
         changed <= 1'b0;
         case (state)
            STABLE: begin
               if (sync2 != stable) begin
                  state <= SETTLING;
                  cand  <= sync2;
                  cnt   <= '0;
               end
            end
            SETTLING: begin
               if (sync2 == stable) begin
                  state <= STABLE;
               end else if (sync2 != cand) begin
                  // a third value restarts settling on the new candidate
                  cand <= sync2;
                  cnt  <= '0;
               end else if (cnt == CNT_MAX) begin
                  stable  <= cand;
                  changed <= 1'b1;
                  state   <= STABLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= STABLE;
         endcase
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Debounces one push-button and a 3-bit slide-switch bank with independent engines.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES  // minimum 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   input  logic [2:0] switch,
   output logic       button_level,
   output logic       button_pulse,
   output logic [2:0] switch_stable,
   output logic       switch_changed
);

   logic btn_stable, btn_changed;

   debounce_core #(
      .WIDTH          (1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk    (clk),
      .rst    (rst),
      .din    (button),
      .stable (btn_stable),
      .changed(btn_changed)
   );

   debounce_core #(
      .WIDTH          (3),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sw (
      .clk    (clk),
      .rst    (rst),
      .din    (switch),
      .stable (switch_stable),
      .changed(switch_changed)
   );

   // both terms are flops, so the press strobe stays glitch-free; release is masked
   assign button_level = btn_stable;
   assign button_pulse = btn_changed & btn_stable;

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 2000000 (20 ms at 100 MHz), the number of consecutive stable cycles required to accept a new input value; legal minimum 2.
REQ-002 clk  input  1  system clock, 100 MHz, all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 button  input  1  raw asynchronous push-button, bouncy.
REQ-005 switch  input  3  raw asynchronous slide switches, bouncy.
REQ-006 button_level  output  1  debounced button state, 1 = pressed.
REQ-007 button_pulse  output  1  one-cycle strobe on each accepted press (0->1 of button_level).
REQ-008 switch_stable  output  3  debounced switch vector.
REQ-009 switch_changed  output  1  one-cycle strobe on each update of switch_stable.

Function
REQ-010 button and each switch bit SHALL pass through a two-flop synchronizer before any other logic; synchronizer flops reset to 0.
REQ-011 The button path and the switch path SHALL each use an independent debounce engine with states STABLE and SETTLING and a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-012 In STABLE, when the synchronized value differs from the accepted value, the engine SHALL enter SETTLING with counter = 0.
REQ-013 In SETTLING, if the synchronized value equals the candidate captured on entry, the counter SHALL increment; on reaching DEBOUNCE_CYCLES-1 the engine SHALL load the candidate as accepted value and return to STABLE.
REQ-014 In SETTLING, if the synchronized value returns to the accepted value, the engine SHALL return to STABLE without output change; if it becomes a different third value (switch path only), the candidate SHALL be replaced and the counter cleared to 0.
REQ-015 Latency: for an input held constant from rising edge N, the accepted value SHALL change at edge N+DEBOUNCE_CYCLES+2 exactly.
REQ-016 button_pulse SHALL be 1 for exactly the first cycle in which button_level is 1; no pulse on release.
REQ-017 switch_changed SHALL be 1 for exactly the first cycle in which switch_stable holds its new value; multi-bit changes accepted together yield a single strobe.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change and no strobe.
REQ-019 Button and switch events occurring in the same cycle SHALL be processed independently with no interaction.
REQ-020 The counter SHALL never wrap; it saturates by construction at DEBOUNCE_CYCLES-1.

Reset
REQ-021 While rst = 1 at a rising edge, all synchronizer flops, accepted values, candidates and counters SHALL clear to 0 and both engines SHALL enter STABLE.
REQ-022 Output reset values: button_level = 0, button_pulse = 0, switch_stable = 3'b000, switch_changed = 0.
REQ-023 Reset asserted mid-SETTLING SHALL abort settling with no strobe; after release, an input already high SHALL be re-debounced from scratch per REQ-015.

Structure
REQ-024 A shared package SHALL hold the engine state encoding (STABLE, SETTLING), the 100 MHz clock constant, the default DEBOUNCE_CYCLES, and the counter-width function.
REQ-025 The debounce engine SHALL be a sub-module debounce_core parameterized by WIDTH and DEBOUNCE_CYCLES, with outputs stable and changed; instantiated with WIDTH=1 (button, button_pulse = changed & stable) and WIDTH=3 (switch).
REQ-026 Outputs SHALL be registered; no combinational path from raw inputs to outputs.

Verification (DEBOUNCE_CYCLES = 8)
REQ-027 Clean press: button 0->1 at edge 10, held -> button_level 1 from edge 20, button_pulse 1 only at edge 20.
REQ-028 Bounce: button high 5 cycles, low 2, high 20 -> no output during first burst; button_level rises 10 edges after the final rising transition, single pulse.
REQ-029 Switch burst: switch 000->101, glitch to 100 for 1 cycle at settling count 4, then 101 held -> switch_stable 101 accepted 10 edges after the return to 101, one switch_changed strobe.
REQ-030 Release: button 1->0 held -> button_level 0 after 10 edges, button_pulse stays 0.
REQ-031 Reset mid-settle: button high, rst=1 for 1 cycle at settling count 5 -> all outputs 0, no pulse; button_level rises 10 edges after rst deasserts.
REQ-032 Simultaneous: button and switch 000->011 change at same edge -> button_pulse and switch_changed both asserted at same edge N+10.
